alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Multi-cycle controller that owns one instance of the 16-bit ALU, which supports ADD, AND, NOT and PASS.
- Sequences that ALU to execute extended macro-ops: SUB, OR, SHL and MUL (low 16 bits).
- Sits beside the SLC-3 datapath as an MMIO-accessible or microcoded coprocessor, with a valid/ready handshake on both command and result sides.
- Produces the result plus LC-3 style NZP flags.

Parameters:
- WIDTH, 16, datapath width; must match the ALU instance.
- MUL_BITS, 16, number of multiplier bits iterated for MUL; MUL takes 2*MUL_BITS steps.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- op_valid  in  1  command valid.
- op_ready  out  1  command accepted when op_valid && op_ready at a rising edge.
- op_code  in  3  macro-op select (see package).
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- flush  in  1  synchronous abort of any in-flight op.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- result  out  WIDTH  macro-op result.
- res_nzp  out  3  {N,Z,P} of result.
- busy  out  1  high in EXEC or DONE.

Behaviour:
- Reset (async, reset_n low): state=IDLE, op_ready=1, res_valid=0, result=0, res_nzp=3'b000, busy=0, all temp registers=0. Reset asserted mid-op discards the op immediately.
- States:
  - IDLE: op_ready=1. On accept, latch op_a/op_b/op_code into regs, step=0, go to EXEC.
  - EXEC: op_ready=0. One ALU operation per cycle; its output is registered at the edge. step increments each cycle. On the final step's edge, go to DONE.
  - DONE: res_valid=1; result and res_nzp stay stable. On res_valid && res_ready, go to IDLE. op_ready stays 0 in DONE; no accept in the same cycle as result handoff.
- Latency: res_valid rises N rising edges after the accepting edge.
  - ADD, AND, NOT, PASS, SHL: N=1.
  - SUB: N=3.
  - OR: N=4.
  - MUL: N=2*MUL_BITS, i.e. 32.
- Step sequences (t, u are temp regs; ALUK as in ALU):
  - ADD: a+b. AND: a&b. NOT: ~a. PASS: a. SHL: a+a (bit 15 discarded).
  - SUB: t=~b; t=t+1; r=a+t.
  - OR: t=~a; u=~b; t=t&u; r=~t.
  - MUL: acc=0 and m=a at accept, q=b. For each bit i in 0..MUL_BITS-1:
    - even step: acc = acc + (q[i] ? m : 0).
    - odd step: m = m + m.
    - Fixed latency regardless of operand values.
- Arithmetic: all results are modulo 2^WIDTH. No carry or overflow output. MUL returns the low WIDTH bits of the product, treated as unsigned (equal to the two's-complement low half).
- res_nzp: exactly one bit set while res_valid. N=result[15], Z=(result==0), P otherwise. Computed from the final registered result.
- flush: highest-priority synchronous event.
  - In EXEC or DONE: next state IDLE, res_valid=0 the next cycle; result keeps its last value; the op is discarded.
  - In IDLE: flush blocks accept that cycle (op_ready forced 0).
- op_code/op_a/op_b changes after accept have no effect until the next accept.
- Only one op is in flight at a time; there is no pipelining.

Decomposition:
- Package alu_seq_pkg holds:
  - macro-op enum op_e: 3'b000 ADD, 001 AND, 010 NOT, 011 PASS, 100 SUB, 101 OR, 110 SHL, 111 MUL.
  - ALUK constants: ALU_ADD=2'b00, ALU_AND=2'b01, ALU_NOT=2'b10, ALU_PASS=2'b11.
  - state enum {IDLE, EXEC, DONE}.
  - function op_steps(op_e) returning N.
- Sub-modules:
  - One ALU instance (the existing alu module) is the only datapath sub-module.
  - Step decode (ALU a/b mux select and ALUK per op and step) is a combinational always block inside this module, not a separate module.

Test Plan:
- SUB: op_a=0x0005, op_b=0x0007 -> result=0xFFFE, res_nzp=3'b100, res_valid rises exactly 3 edges after accept.
- OR: op_a=0x0F0F, op_b=0x00FF -> result=0x0FFF, res_nzp=3'b001 at 4 edges. NOT with op_a=0xFFFF -> 0x0000, res_nzp=3'b010 at 1 edge.
- MUL:
  - 0x0003*0x0005 -> 0x000F, res_valid at edge 32.
  - 0x0100*0x0100 -> 0x0000, nzp=010.
  - 0xFFFF*0x0002 -> 0xFFFE, nzp=100.
- Backpressure: ADD 0x1234+0x0001 with res_ready held low for 5 cycles -> result=0x1235 stable, res_valid=1, op_ready=0 throughout. Pulse op_valid with a new op meanwhile -> not accepted.
- Flush: assert flush during MUL step 10 -> next cycle state IDLE, op_ready=1, res_valid never asserted. A following ADD 2+2 -> 0x0004 at 1 edge.
- Async reset: drop reset_n mid-SUB, asynchronously to clk -> res_valid=0, result=0, res_nzp=000, busy=0 immediately. After release, accepting a new op works normally.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU macro-op sequencer.
//   op_e     - macro-op encoding presented on op_code.
//   ALU_*    - ALUK select values of the 16-bit ALU (ADD, AND, NOT, PASS).
//   state_e  - sequencer control states.
//   dst_e    - which register captures the ALU output on a given step.
//   op_steps - number of ALU steps (and so edges of latency) for a macro-op.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_AND  = 3'b001,
        OP_NOT  = 3'b010,
        OP_PASS = 3'b011,
        OP_SUB  = 3'b100,
        OP_OR   = 3'b101,
        OP_SHL  = 3'b110,
        OP_MUL  = 3'b111
    } op_e;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_NOT  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        DST_T = 2'b00,
        DST_U = 2'b01,
        DST_R = 2'b10
    } dst_e;

    // Every step is one ALU pass; MUL alternates accumulate / double per multiplier bit.
    function automatic int unsigned op_steps(input op_e op, input int unsigned mul_bits = 16);
        case (op)
            OP_SUB:  return 3;
            OP_OR:   return 4;
            OP_MUL:  return 2 * mul_bits;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: command and result bundle of the ALU macro-op sequencer.
//   Command side : op_valid, op_ready, op_code, op_a, op_b, flush.
//   Result side  : res_valid, res_ready, result, res_nzp, busy.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready are
// both high. The sender holds valid and its payload until that edge; ready may
// depend combinationally on the current state and on flush, never on valid.
// result/res_nzp are stable for as long as res_valid stays high.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;
    logic [2:0]       res_nzp;
    logic             busy;

    // Issuer of commands and consumer of results.
    modport master (
        output op_valid, op_code, op_a, op_b, flush, res_ready,
        input  op_ready, res_valid, result, res_nzp, busy
    );

    // The sequencer itself.
    modport slave (
        input  op_valid, op_code, op_a, op_b, flush, res_ready,
        output op_ready, res_valid, result, res_nzp, busy
    );
endinterface

// File: rtl/alu_op_sequencer_alu.sv
// alu: the existing single-cycle 16-bit ALU (combinational).
//   a, b  - operands.
//   aluk  - operation select: ADD, AND, NOT (of a), PASS (a).
//   y     - result, modulo 2^WIDTH.
module alu
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       aluk,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        y = a;
        case (aluk)
            ALU_ADD: y = a + b;
            ALU_AND: y = a & b;
            ALU_NOT: y = ~a;
            default: y = a;
        endcase
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle controller that drives one ADD/AND/NOT/PASS ALU
// to execute the macro-ops ADD, AND, NOT, PASS, SUB, OR, SHL and MUL (low half).
//   clk       - rising-edge clock.
//   reset_n   - asynchronous active-low reset; discards any op in flight.
//   bus       - slave side of alu_op_sequencer_if (command, result, flush, busy).
//   dbg_state - current control state, for observation only.
// One op is in flight at a time. Result and NZP change only on the final step.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int MUL_BITS = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    alu_op_sequencer_if.slave        bus,
    output state_e                   dbg_state
);
    localparam int SW = $clog2(2 * MUL_BITS + 1);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q,  state_d;
    logic [SW-1:0]    step_q,   step_d;
    op_e              op_q,     op_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;       // also the MUL multiplier q
    logic [WIDTH-1:0] t_q,      t_d;       // temp t; MUL accumulator
    logic [WIDTH-1:0] u_q,      u_d;       // temp u; MUL shifted multiplicand m
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       nzp_q,    nzp_d;

    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic [1:0]       aluk;
    dst_e             dst;
    logic [WIDTH-1:0] mul_sh;
    logic [SW-1:0]    last_step;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .aluk (aluk),
        .y    (alu_y)
    );

    assign last_step = SW'(op_steps(op_q, MUL_BITS) - 1);

    // Step decode: ALU operand mux, ALUK and destination for the current op/step.
    always_comb begin
        alu_a  = a_q;
        alu_b  = b_q;
        aluk   = ALU_PASS;
        dst    = DST_R;
        // Multiplier bit for this pair of MUL steps lives at index step/2.
        mul_sh = b_q >> step_q[SW-1:1];
        case (op_q)
            OP_ADD:  aluk = ALU_ADD;
            OP_AND:  aluk = ALU_AND;
            OP_NOT:  aluk = ALU_NOT;
            OP_PASS: aluk = ALU_PASS;
            OP_SHL: begin
                alu_b = a_q;
                aluk  = ALU_ADD;
            end
            OP_SUB: begin
                case (step_q)
                    SW'(0): begin alu_a = b_q; aluk = ALU_NOT; dst = DST_T; end
                    SW'(1): begin alu_a = t_q; alu_b = ONE; aluk = ALU_ADD; dst = DST_T; end
                    default: begin alu_a = a_q; alu_b = t_q; aluk = ALU_ADD; dst = DST_R; end
                endcase
            end
            OP_OR: begin
                case (step_q)
                    SW'(0): begin alu_a = a_q; aluk = ALU_NOT; dst = DST_T; end
                    SW'(1): begin alu_a = b_q; aluk = ALU_NOT; dst = DST_U; end
                    SW'(2): begin alu_a = t_q; alu_b = u_q; aluk = ALU_AND; dst = DST_T; end
                    default: begin alu_a = t_q; aluk = ALU_NOT; dst = DST_R; end
                endcase
            end
            OP_MUL: begin
                if (!step_q[0]) begin
                    alu_a = t_q;
                    alu_b = mul_sh[0] ? u_q : '0;
                    aluk  = ALU_ADD;
                    dst   = DST_T;
                end else begin
                    alu_a = u_q;
                    alu_b = u_q;
                    aluk  = ALU_ADD;
                    dst   = DST_U;
                end
            end
            default: aluk = ALU_PASS;
        endcase
    end

    // Control FSM next state and register updates. Flush overrides everything.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        t_d      = t_q;
        u_d      = u_q;
        result_d = result_q;
        nzp_d    = nzp_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.op_valid) begin
                        op_d    = op_e'(bus.op_code);
                        a_d     = bus.op_a;
                        b_d     = bus.op_b;
                        t_d     = '0;
                        u_d     = bus.op_a;
                        step_d  = '0;
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    case (dst)
                        DST_T:   t_d      = alu_y;
                        DST_U:   u_d      = alu_y;
                        default: result_d = alu_y;
                    endcase
                    step_d = step_q + SW'(1);
                    if (step_q == last_step) begin
                        // MUL ends on a doubling step; the product is already in t.
                        if (op_q == OP_MUL) begin
                            result_d = t_q;
                        end
                        nzp_d   = result_d[WIDTH-1] ? 3'b100 :
                                  (result_d == '0)  ? 3'b010 : 3'b001;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            step_q   <= '0;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            t_q      <= '0;
            u_q      <= '0;
            result_q <= '0;
            nzp_q    <= 3'b000;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            t_q      <= t_d;
            u_q      <= u_d;
            result_q <= result_d;
            nzp_q    <= nzp_d;
        end
    end

    assign bus.op_ready  = (state_q == IDLE) && !bus.flush;
    assign bus.res_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = result_q;
    assign bus.res_nzp   = nzp_q;
    assign dbg_state     = state_q;

endmodule
